// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// FSM state encoding, default widths and the length clamp helper.
package seq_tx_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  function automatic int clamp_len(
    input int l,
    input int w
  );
    return (l > w) ? w : l;
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Saturating down counter with load, enable and a terminal flag.
// ZERO_TERM selects terminal at zero instead of at one.
module seq_down_cnt #(
  parameter int W         = 4,
  parameter bit ZERO_TERM = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  if (ZERO_TERM) begin : g_zero
    assign term = (cnt == '0);
  end else begin : g_one
    assign term = (cnt == W'(1));
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first shift-out of a captured
// pattern, repeated with an optional idle gap between repetitions.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  tx_state_t state, state_n;

  logic [PAT_W-1:0] sr, pat_q, pat_al;
  logic [LEN_W-1:0] len_eff, len_q, bit_val;
  logic [CNT_W-1:0] gap_q;

  logic cap, clr, sr_load, sr_shift;
  logic bit_load, bit_en, bit_last;
  logic gap_load, gap_en, gap_last;
  logic rep_load, rep_en, rep_zero;

  assign len_eff = LEN_W'(clamp_len(int'(len), PAT_W));
  // Left-align so the first emitted bit always sits in the MSB.
  assign pat_al  = pattern << (PAT_W - int'(len_eff));
  assign bit_val = (state == IDLE) ? len_eff : len_q;

  seq_down_cnt #(.W(LEN_W), .ZERO_TERM(1'b0)) u_bit_cnt (
    .clk(clk), .rst(rst), .clr(clr),
    .load(bit_load), .en(bit_en),
    .load_val(bit_val), .term(bit_last)
  );

  seq_down_cnt #(.W(CNT_W), .ZERO_TERM(1'b0)) u_gap_cnt (
    .clk(clk), .rst(rst), .clr(clr),
    .load(gap_load), .en(gap_en),
    .load_val(gap_q), .term(gap_last)
  );

  seq_down_cnt #(.W(CNT_W), .ZERO_TERM(1'b1)) u_rep_cnt (
    .clk(clk), .rst(rst), .clr(clr),
    .load(rep_load), .en(rep_en),
    .load_val(reps), .term(rep_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= '0;
      gap_q <= '0;
    end else if (cap) begin
      pat_q <= pat_al;
      len_q <= len_eff;
      gap_q <= gap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (cap) begin
      sr <= pat_al;
    end else if (sr_load) begin
      sr <= pat_q;
    end else if (sr_shift) begin
      sr <= sr << 1;
    end
  end

  always_comb begin
    state_n  = state;
    cap      = 1'b0;
    clr      = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    bit_load = 1'b0;
    bit_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    rep_load = 1'b0;
    rep_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cap      = 1'b1;
          bit_load = 1'b1;
          rep_load = 1'b1;
          state_n  = (len_eff != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          clr     = 1'b1;
          state_n = IDLE;
        end else begin
          bit_en   = 1'b1;
          sr_shift = 1'b1;
          if (bit_last) begin
            if (rep_zero) begin
              state_n = DONE;
            end else if (gap_q != '0) begin
              gap_load = 1'b1;
              state_n  = GAP;
            end else begin
              sr_load  = 1'b1;
              bit_load = 1'b1;
              rep_en   = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          clr     = 1'b1;
          state_n = IDLE;
        end else begin
          gap_en = 1'b1;
          if (gap_last) begin
            sr_load  = 1'b1;
            bit_load = 1'b1;
            rep_en   = 1'b1;
            state_n  = SHIFT;
          end
        end
      end
      DONE: begin
        clr     = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign valid = (state == SHIFT);
  assign x     = valid && sr[PAT_W-1];
  assign busy  = (state == SHIFT) || (state == GAP);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed vector table,
// hand-written abort/reset sequences and a randomized stream model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       x, valid, busy, done;
  logic [3:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  int txn_id = 0;

  always #5 clk = ~clk;

  assign outs = {x, valid, busy, done};

  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .reps(reps), .gap(gap),
    .x(x), .valid(valid), .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0]  p;
    logic [3:0]  l;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [31:0] bits;
    int          nb;
    int          bz;
  } vec_t;

  vec_t vt[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [31:0] bits;
    int nb, bz, dc;
    pattern = v.p; len = v.l; reps = v.r; gap = v.g;
    start = 1'b1;
    tick;
    start = 1'b0;
    bits = '0; nb = 0; bz = 0; dc = -1;
    for (int c = 1; c <= 200 && dc < 0; c++) begin
      if (valid) begin
        bits = {bits[30:0], x};
        nb++;
      end
      if (busy) bz++;
      if (done) dc = c;
      else tick;
    end
    chk($sformatf("vec%0d_bits", id), bits, v.bits);
    chk($sformatf("vec%0d_nbits", id), 32'(nb), 32'(v.nb));
    chk($sformatf("vec%0d_busy", id), 32'(bz), 32'(v.bz));
    chk($sformatf("vec%0d_done_at", id), 32'(dc), 32'(v.bz + 1));
    tick;
    chk($sformatf("vec%0d_idle", id), 32'(outs), 32'h0);
  endtask

  task automatic run_txn(input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input logic [3:0] g);
    logic [3:0] q[$];
    int le;
    le = (int'(l) > 8) ? 8 : int'(l);
    if (le > 0) begin
      for (int k = 0; k <= int'(r); k++) begin
        for (int b = le - 1; b >= 0; b--) q.push_back({p[b], 3'b110});
        if (k < int'(r))
          for (int j = 0; j < int'(g); j++) q.push_back(4'b0010);
      end
    end
    q.push_back(4'b0001);
    q.push_back(4'b0000);
    pattern = p; len = l; reps = r; gap = g;
    start = 1'b1;
    tick;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("txn%0d_c%0d", txn_id, i), 32'(outs), 32'(q[i]));
      if (i < q.size() - 1) begin
        start   = 1'($urandom);
        pattern = 8'($urandom);
        len     = 4'($urandom);
        reps    = 4'($urandom);
        gap     = 4'($urandom);
        tick;
      end
    end
    start = 1'b0;
    txn_id++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h0A, 4'd4,  4'd0, 4'd0, 32'hA,    4,  4};
    vt[1] = '{8'h0B, 4'd4,  4'd2, 4'd3, 32'hBBB,  12, 18};
    vt[2] = '{8'h05, 4'd3,  4'd1, 4'd0, 32'h2D,   6,  6};
    vt[3] = '{8'hA5, 4'd15, 4'd0, 4'd0, 32'hA5,   8,  8};
    vt[4] = '{8'hFF, 4'd0,  4'd2, 4'd2, 32'h0,    0,  0};
    vt[5] = '{8'h81, 4'd8,  4'd1, 4'd1, 32'h8181, 16, 17};
    vt[6] = '{8'h06, 4'd2,  4'd3, 4'd0, 32'hAA,   8,  8};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; reps = '0; gap = '0;
    #1;
    chk("reset_t1", 32'(outs), 32'h0);
    start = 1'b1;
    tick;
    chk("reset_hold", 32'(outs), 32'h0);
    start = 1'b0;
    rst = 1'b0;
    tick;
    chk("idle_after_reset", 32'(outs), 32'h0);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // abort during the second bit
    pattern = 8'h0A; len = 4'd4; reps = 4'd0; gap = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("abort_bit1", 32'(outs), 32'hE);
    tick;
    chk("abort_bit2", 32'(outs), 32'h6);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_idle", 32'(outs), 32'h0);
    tick;
    chk("abort_no_done", 32'(outs), 32'h0);

    // start beats abort in IDLE
    pattern = 8'h03; len = 4'd2;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("start_wins_b1", 32'(outs), 32'hE);
    tick;
    chk("start_wins_b2", 32'(outs), 32'hE);
    tick;
    chk("start_wins_done", 32'(outs), 32'h1);
    tick;
    chk("start_wins_idle", 32'(outs), 32'h0);
    run_txn(8'h5A, 4'd8, 4'd1, 4'd2);

    // async reset between edges while in GAP
    pattern = 8'h01; len = 4'd1; reps = 4'd1; gap = 4'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rst_bit", 32'(outs), 32'hE);
    tick;
    chk("rst_gap", 32'(outs), 32'h2);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(outs), 32'h0);
    #2;
    rst = 1'b0;
    tick;
    chk("rst_idle1", 32'(outs), 32'h0);
    tick;
    chk("rst_idle2", 32'(outs), 32'h0);
    run_txn(8'hC3, 4'd6, 4'd2, 4'd1);

    for (int t = 0; t < 40; t++) begin
      int idle_n;
      idle_n = $urandom_range(0, 2);
      for (int k = 0; k < idle_n; k++) begin
        tick;
        chk("rand_idle", 32'(outs), 32'h0);
      end
      run_txn(8'($urandom), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter. It captures a programmable bit pattern on a start request and shifts it out MSB-first, one bit per clock. The pattern is repeated a programmable number of times, with a programmable idle gap between repetitions. It is the stimulus/transmit end for the sequence-detector blocks, driving their serial `x` input, and reports busy/done status to a controlling FSM or testbench.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits.
- `LEN_W`, default 4: width of `len`; must satisfy 2^LEN_W > PAT_W.
- `CNT_W`, default 4: width of `reps` and `gap`.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request transmission; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel; returns to IDLE with no done pulse.
- `pattern`, in, PAT_W: pattern, LSB-aligned; captured on accepted start.
- `len`, in, LEN_W: bits per repetition; captured on accepted start.
- `reps`, in, CNT_W: extra repetitions (total = reps+1); captured on accepted start.
- `gap`, in, CNT_W: idle cycles between repetitions; captured on accepted start.
- `x`, out, 1: serial data out.
- `valid`, out, 1: `x` carries a pattern bit this cycle.
- `busy`, out, 1: high in SHIFT and GAP.
- `done`, out, 1: one-cycle pulse after the final bit.

## Operation
- Moore FSM with states IDLE, SHIFT, GAP, DONE. All outputs decode from the state and the shift register only; no input-to-output combinational path.
- **IDLE:** `x=0`, `valid=0`, `busy=0`, `done=0`.
  - On `start=1` with effective length ≥1: capture the inputs, load the shift register, go to SHIFT.
  - On `start=1` with `len=0`: capture, go directly to DONE.
- **Effective length:** `len` > PAT_W is clamped to PAT_W.
- **Bit order:** bits are emitted `pattern[len-1]` down to `pattern[0]`. Example: `pattern=8'h0A`, `len=4` emits 1,0,1,0.
- **SHIFT:** `valid=1`, `busy=1`, `x` = current bit. The bit counter decrements each cycle. On the last bit:
  - If repetitions remain and `gap>0`: go to GAP.
  - If repetitions remain and `gap=0`: reload the shift register and stay in SHIFT; the next repetition starts back-to-back.
  - Otherwise: go to DONE.
- **GAP:** `x=0`, `valid=0`, `busy=1` for exactly `gap` cycles. Then reload the shift register, decrement the repetition counter, go to SHIFT.
- **DONE:** `done=1`, `busy=0` for one cycle, then IDLE. `start` during DONE is ignored.
- **Start while busy:** ignored. Captured values are not disturbed by input changes mid-transfer.
- **abort=1 in SHIFT/GAP/DONE:** next state IDLE, counters cleared, `done` not asserted. `abort` in IDLE has no effect. If `abort` and `start` are high in the same IDLE cycle, `start` wins.
- **Counter widths:**
  - bit counter LEN_W
  - gap counter CNT_W
  - repetition counter CNT_W
  - None of them wrap. Terminal detection is `==1` before decrement for the bit and gap counters, and `==0` for the repetition counter.

## Timing
- **Reset:** `rst` forces IDLE asynchronously. `x`, `valid`, `busy`, `done` and all counters read 0 immediately. Reset mid-transfer truncates the output with no done pulse.
- **Start latency:** with `start` sampled high at edge k, the first bit appears on `x`/`valid` in the cycle after edge k.
- **Busy duration:** `busy` is high for (reps+1)·len + reps·gap cycles. `done` asserts in the cycle after the final bit.
- **Next start:** earliest accepted next `start` is in the cycle after DONE, i.e. a 2-cycle turnaround from the last bit.
- **Output changes:** outputs change only on rising `clk` edges, or asynchronously on `rst`.

## Structure
- **Package `seq_tx_pkg`:** state encoding localparams (IDLE, SHIFT, GAP, DONE), default PAT_W/LEN_W/CNT_W constants, and the clamp-length function.
- **Sub-module `seq_down_cnt`** (load/enable/terminal flag), instantiated three times: bit, gap, and repetition counters.
- **Top:** FSM, shift register, capture registers.

## Test plan
- **Basic 1010:** `pattern=8'h0A`, `len=4`, `reps=0`, `gap=0`, pulse `start` -> `x`=1,0,1,0 with `valid=1` for 4 cycles starting 1 cycle after the start edge; `done` pulse on cycle 5; `busy` high exactly 4 cycles.
- **Repeat with gap:** `pattern=8'h0B`, `len=4`, `reps=2`, `gap=3` -> 1011, 3 idle cycles, 1011, 3 idle cycles, 1011, then `done`; `busy`=18 cycles.
- **Back-to-back repeat:** `pattern=8'h05`, `len=3`, `reps=1`, `gap=0` -> 101101 contiguous with `valid` never dropping; then `done`.
- **Boundary lengths:**
  - `len=0` -> `done` 1 cycle after start, `valid` never high.
  - `len=15` with PAT_W=8 -> exactly 8 bits, MSB first.
- **Abort and restart:** `abort` in the second bit of a 4-bit transfer -> IDLE next cycle with no `done`. `start` during busy is ignored. A new `start` after abort transmits a fresh pattern correctly.
- **Async reset:** assert `rst` mid-GAP between clock edges -> all outputs 0 immediately. After release, IDLE; a new `start` works normally.
